// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall control, IF/ID register.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_err
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  logic [31:0] r_pc;
  if_id_t      r_if_id;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_squash;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_squash   = flush | branch_taken;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign_err;

  assign w_target   = branch_target;
  assign w_misalign = branch_taken & (branch_target[1:0] != 2'b00);

  // Sticky until reset so software/debug can observe the trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else if (w_misalign) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign misalign_err = r_misalign_err;
`else
  assign w_target     = branch_target & ~32'h0000_0003;
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Redirect outranks stall so a taken branch is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (branch_taken) begin
      if (!w_misalign) begin
        r_pc <= w_target;
      end
    end else if (!stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_id.pc       <= 32'h0;
      r_if_id.pc_plus4 <= 32'h0;
      r_if_id.instr    <= NOP_INSTR;
      r_if_id.valid    <= 1'b0;
    end else if (w_squash) begin
      r_if_id.instr <= NOP_INSTR;
      r_if_id.valid <= 1'b0;
    end else if (!stall) begin
      r_if_id.pc       <= r_pc;
      r_if_id.pc_plus4 <= w_pc_plus4;
      r_if_id.instr    <= imem_instr;
      r_if_id.valid    <= 1'b1;
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_pc       = r_if_id.pc;
  assign if_id_pc_plus4 = r_if_id.pc_plus4;
  assign if_id_instr    = r_if_id.instr;
  assign if_id_valid    = r_if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free-run, stall, redirect,
// flush, wrap-around, misaligned redirect and mid-stream reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .misalign_err   (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   mem = 32'h0050_0093;
      32'h4:   mem = 32'h0030_0113;
      32'h8:   mem = 32'h0020_81b3;
      default: mem = 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  assign imem_instr = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_pc"}, if_id_pc, 32'h0);
    chk({tag, "_pc4"}, if_id_pc_plus4, 32'h0);
    chk({tag, "_instr"}, if_id_instr, NOP);
    chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
    chk({tag, "_mis"}, {31'h0, misalign_err}, 32'h0);
  endtask

  initial begin
    stall = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    rst = 1'b1;
    step();
    chk_reset("rst");
    step();
    rst = 1'b0;
    chk("rel_addr", imem_addr, 32'h0);

    // free run
    step();
    chk("e1_instr", if_id_instr, 32'h0050_0093);
    chk("e1_pc", if_id_pc, 32'h0);
    chk("e1_valid", {31'h0, if_id_valid}, 32'h1);
    chk("e1_addr", imem_addr, 32'h4);
    step();
    chk("e2_instr", if_id_instr, 32'h0030_0113);
    chk("e2_pc", if_id_pc, 32'h4);
    chk("e2_pc4", if_id_pc_plus4, 32'h8);
    step();
    chk("e3_instr", if_id_instr, 32'h0020_81b3);
    chk("e3_pc", if_id_pc, 32'h8);
    chk("e3_valid", {31'h0, if_id_valid}, 32'h1);

    // redirect back to 0
    branch_taken = 1'b1;
    branch_target = 32'h0;
    step();
    branch_taken = 1'b0;
    chk("rd0_addr", imem_addr, 32'h0);
    chk("rd0_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rd0_instr", if_id_instr, NOP);
    chk("rd0_pc_kept", if_id_pc, 32'h8);
    step();
    chk("rd1_pc", if_id_pc, 32'h0);
    chk("rd1_valid", {31'h0, if_id_valid}, 32'h1);
    step();
    chk("pre_st_addr", imem_addr, 32'h8);
    chk("pre_st_pc", if_id_pc, 32'h4);

    // two-cycle stall at PC=8
    stall = 1'b1;
    step();
    chk("st1_addr", imem_addr, 32'h8);
    chk("st1_pc", if_id_pc, 32'h4);
    chk("st1_instr", if_id_instr, 32'h0030_0113);
    step();
    chk("st2_addr", imem_addr, 32'h8);
    chk("st2_pc", if_id_pc, 32'h4);
    stall = 1'b0;
    step();
    chk("st_res_pc", if_id_pc, 32'h8);
    chk("st_res_instr", if_id_instr, 32'h0020_81b3);
    chk("st_res_addr", imem_addr, 32'hC);

    // branch with simultaneous stall
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step();
    stall = 1'b0;
    branch_taken = 1'b0;
    chk("bs_addr", imem_addr, 32'h40);
    chk("bs_valid", {31'h0, if_id_valid}, 32'h0);
    chk("bs_instr", if_id_instr, NOP);
    chk("bs_pc_kept", if_id_pc, 32'h8);
    step();
    chk("bs_tgt_pc", if_id_pc, 32'h40);
    chk("bs_tgt_pc4", if_id_pc_plus4, 32'h44);
    chk("bs_tgt_instr", if_id_instr, 32'hC0DE_0040);
    chk("bs_tgt_valid", {31'h0, if_id_valid}, 32'h1);

    // flush only: bubble, PC still advances
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", {31'h0, if_id_valid}, 32'h0);
    chk("fl_instr", if_id_instr, NOP);
    chk("fl_pc_kept", if_id_pc, 32'h40);
    chk("fl_addr", imem_addr, 32'h48);
    step();
    chk("fl_next_pc", if_id_pc, 32'h48);

    // wrap-around
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_addr1", imem_addr, 32'h0);
    chk("wr_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", if_id_pc_plus4, 32'h0);

    // misaligned redirect (PC is 0 here)
    branch_taken = 1'b1;
    branch_target = 32'h42;
    step();
    branch_taken = 1'b0;
    chk("mis_valid", {31'h0, if_id_valid}, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_addr", imem_addr, 32'h0);
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    step();
    chk("mis_err_sticky", {31'h0, misalign_err}, 32'h1);
    chk("mis_next_pc", if_id_pc, 32'h0);
`else
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_err", {31'h0, misalign_err}, 32'h0);
    step();
    chk("mis_err_low", {31'h0, misalign_err}, 32'h0);
    chk("mis_next_pc", if_id_pc, 32'h40);
`endif

    // mid-stream async reset at PC=0x20 with redirect and stall pending
    branch_taken = 1'b1;
    branch_target = 32'h1C;
    step();
    branch_taken = 1'b0;
    step();
    chk("pre_rst_addr", imem_addr, 32'h20);
    chk("pre_rst_pc", if_id_pc, 32'h1C);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h80;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    step();
    chk_reset("arst_hold");
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("rst2_addr", imem_addr, 32'h0);
    step();
    chk("rst2_pc", if_id_pc, 32'h0);
    chk("rst2_instr", if_id_instr, 32'h0050_0093);
    chk("rst2_valid", {31'h0, if_id_valid}, 32'h1);
    chk("rst2_addr4", imem_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), which is the bubble instruction.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port stall, input, 1 bit: hazard-unit hold of PC and IF/ID.
REQ-006 SHALL provide port flush, input, 1 bit: squash IF/ID contents.
REQ-007 SHALL provide port branch_taken, input, 1 bit: EX-stage redirect request.
REQ-008 SHALL provide port branch_target, input, 32 bits: redirect byte address.
REQ-009 SHALL provide port imem_addr, output, 32 bits: byte address driven to instruction memory addr.
REQ-010 SHALL provide port imem_instr, input, 32 bits: combinational instruction returned by instruction memory.
REQ-011 SHALL provide port if_id_pc, output, 32 bits: PC of the registered instruction.
REQ-012 SHALL provide port if_id_pc_plus4, output, 32 bits: if_id_pc + 4.
REQ-013 SHALL provide port if_id_instr, output, 32 bits: registered instruction.
REQ-014 SHALL provide port if_id_valid, output, 1 bit: IF/ID holds a real instruction.
REQ-015 SHALL provide port misalign_err, output, 1 bit: sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL drive imem_addr combinationally from the PC register, with zero added latency.
REQ-017 SHALL update PC on each rising edge as follows: branch_taken=1 -> branch_target; else stall=1 -> hold; else PC+4.
REQ-018 SHALL give branch_taken priority over stall, so a redirect is never lost to a simultaneous stall.
REQ-019 SHALL compute PC+4 modulo 2^32, so PC 32'hFFFF_FFFC advances to 32'h0000_0000, with no range check against memory size.
REQ-020 SHALL load IF/ID, when flush=1 or branch_taken=1 (regardless of stall), with instr=NOP_INSTR and valid=0, leaving pc fields unchanged.
REQ-021 SHALL hold every IF/ID field unchanged when stall=1 and neither flush nor branch_taken is asserted.
REQ-022 SHALL otherwise load IF/ID with pc<=PC, pc_plus4<=PC+4, instr<=imem_instr and valid<=1.
REQ-023 SHALL present the instruction fetched at address A on if_id_instr exactly one clock edge after imem_addr=A, giving a latency of 1 cycle.
REQ-024 SHALL sustain a throughput of one instruction per cycle when stall, flush and branch_taken are all 0.
REQ-025 SHALL make if_id_valid=0 for exactly one cycle after a redirect, with the target instruction valid on the following edge unless stalled.

Reset
REQ-026 SHALL, while rst=1 and asynchronously, force PC=RESET_PC, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=NOP_INSTR, if_id_valid=0 and misalign_err=0.
REQ-027 SHALL, on rst deassertion, fetch RESET_PC in the first cycle and assert if_id_valid at the first subsequent rising edge.
REQ-028 SHALL discard an in-flight redirect or stall when reset is asserted mid-operation, with no state surviving reset.

Configuration
REQ-029 SHALL gate the misaligned-redirect check with macro FETCH_MISALIGN_CHECK_EN.
REQ-030 SHALL, when FETCH_MISALIGN_CHECK_EN is defined and branch_taken=1 with branch_target[1:0]!=2'b00, hold PC, flush IF/ID, and set misalign_err at that edge, keeping it set until rst.
REQ-031 SHALL, when FETCH_MISALIGN_CHECK_EN is undefined, load branch_target with bits [1:0] forced to 2'b00 and tie misalign_err to 0.

Verification
REQ-032 SHALL cover reset then free-run with RESET_PC=0 and memory words 0x00500093, 0x00300113, 0x002081b3: if_id_instr reads those values on edges 1-3, if_id_valid=1 and if_id_pc=0/4/8.
REQ-033 SHALL cover stall=1 for 2 cycles at PC=8: imem_addr stays 8 and IF/ID holds pc=4 for 2 cycles, then resumes at pc=8.
REQ-034 SHALL cover branch_taken=1 with target=0x40 while stall=1: next imem_addr=0x40, if_id_valid=0 and if_id_instr=0x00000013 for 1 cycle, then if_id_pc=0x40.
REQ-035 SHALL cover wrap-around from PC=0xFFFFFFFC via redirect: the next imem_addr is 0x00000000 and if_id_pc_plus4 for that instruction is 0x00000000.
REQ-036 SHALL cover target=0x42 with the macro defined: PC holds, misalign_err=1 and stays 1. Without the macro: imem_addr=0x40 and misalign_err=0.
REQ-037 SHALL cover rst pulsed mid-stream at PC=0x20: all outputs take their reset values immediately (asynchronously) and fetch restarts at RESET_PC.
